// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB boundary of the MIPS32 core.
// Holds reset/write-enable levels, bus widths, load-type codes and the
// bit positions of the stall vector driven by the pipeline controller.
package mem_wb_stage_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        RstDisable   = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LBU  = 3'b010,
    LD_LH   = 3'b011,
    LD_LHU  = 3'b100,
    LD_LW   = 3'b101
  } ld_type_e;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational big-endian load data extraction.
// Selects the byte/halfword lane from the raw memory word, applies sign or
// zero extension, and flags misaligned halfword/word loads. Non-load and
// reserved load types pass the ALU/move result through.
// Ports:
//   ld_type    - load type code (ld_type_e values, 110/111 treated as none)
//   addr_lo    - effective address bits 1:0
//   rdata      - raw word from data memory
//   wdata      - non-load result
//   data       - value destined for the register file
//   misaligned - load address not aligned to its access size
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian: the lowest address holds the most significant lane.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_sel = rdata[31:24];
      2'b01:   byte_sel = rdata[23:16];
      2'b10:   byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    data       = wdata;
    misaligned = 1'b0;
    case (ld_type)
      LD_LB:   data = ext8(byte_sel, 1'b1);
      LD_LBU:  data = ext8(byte_sel, 1'b0);
      LD_LH: begin
        data       = ext16(half_sel, 1'b1);
        misaligned = addr_lo[0];
      end
      LD_LHU: begin
        data       = ext16(half_sel, 1'b0);
        misaligned = addr_lo[0];
      end
      LD_LW: begin
        data       = rdata;
        misaligned = |addr_lo;
      end
      default: data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register of the 5-stage MIPS32 core.
// Captures MEM results under stall/flush control, aligns load data, drives
// the register-file write port and owns the architectural HI/LO registers
// (with a combinational bypass of the WB slot for the EX stage).
// Optional feature macro: MEM_WB_LLBIT_EN adds the LLbit register and its
// ports (mem_llbit_we, mem_llbit_val, llbit_o) for LL/SC support.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   stall[5:0]           - controller stall vector (bit3 MEM, bit4 WB)
//   flush                - exception flush, kills the WB slot
//   mem_wreg/wd/wdata    - GPR write request, target and non-load result
//   mem_ld_type/addr/rdata - load type, effective address, raw memory word
//   mem_whilo/hi/lo      - HI/LO write request and values
//   wr_en/wraddr/wrdata  - register file write port
//   adel                 - misaligned load flag for the captured slot
//   hi_o/lo_o            - bypassed HI/LO read for EX
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_ld_type,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wraddr,
  output logic [DATA_W-1:0] wrdata,
  output logic              adel,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
`ifdef MEM_WB_LLBIT_EN
  ,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_val,
  output logic              llbit_o
`endif
);

  logic [DATA_W-1:0] ld_data;
  logic              ld_misaligned;
  logic              bubble;
  logic              capture;

  logic              whilo_p0;
  logic [DATA_W-1:0] hi_p0;
  logic [DATA_W-1:0] lo_p0;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;

  logic unused_ok;
  assign unused_ok = ^{mem_addr[DATA_W-1:2], stall[5], stall[2:0]};

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_type    (mem_ld_type),
    .addr_lo    (mem_addr[1:0]),
    .rdata      (mem_rdata),
    .wdata      (mem_wdata),
    .data       (ld_data),
    .misaligned (ld_misaligned)
  );

  // A stalled MEM with a running WB must not replay its result into WB.
  assign bubble  = flush || (stall[STALL_MEM] && !stall[STALL_WB]);
  assign capture = !stall[STALL_MEM];

  // ---- MEM -> WB stage register ----
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_en    <= WriteDisable;
      wraddr   <= '0;
      wrdata   <= ZeroWord;
      adel     <= 1'b0;
      whilo_p0 <= 1'b0;
      hi_p0    <= ZeroWord;
      lo_p0    <= ZeroWord;
    end else if (bubble) begin
      wr_en    <= WriteDisable;
      wraddr   <= '0;
      wrdata   <= ZeroWord;
      adel     <= 1'b0;
      whilo_p0 <= 1'b0;
      hi_p0    <= ZeroWord;
      lo_p0    <= ZeroWord;
    end else if (capture) begin
      // A misaligned load raises adel instead of writing the GPR.
      wr_en    <= mem_wreg && !ld_misaligned;
      wraddr   <= mem_wd;
      wrdata   <= ld_data;
      adel     <= ld_misaligned;
      whilo_p0 <= mem_whilo;
      hi_p0    <= mem_hi;
      lo_p0    <= mem_lo;
    end
  end

  // ---- WB -> architectural HI/LO commit ----
  // Commits on the same edge as the register file; a flush cancels it.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_reg <= ZeroWord;
      lo_reg <= ZeroWord;
    end else if (!flush && whilo_p0) begin
      hi_reg <= hi_p0;
      lo_reg <= lo_p0;
    end
  end

  assign hi_o = whilo_p0 ? hi_p0 : hi_reg;
  assign lo_o = whilo_p0 ? lo_p0 : lo_reg;

`ifdef MEM_WB_LLBIT_EN
  logic llbit_we_p0;
  logic llbit_val_p0;
  logic llbit_reg;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || bubble) begin
      llbit_we_p0  <= 1'b0;
      llbit_val_p0 <= 1'b0;
    end else if (capture) begin
      llbit_we_p0  <= mem_llbit_we;
      llbit_val_p0 <= mem_llbit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      llbit_reg <= 1'b0;
    end else if (llbit_we_p0) begin
      llbit_reg <= llbit_val_p0;
    end
  end

  assign llbit_o = llbit_we_p0 ? llbit_val_p0 : llbit_reg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        wr_en;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        adel;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
`ifdef MEM_WB_LLBIT_EN
  logic        mem_llbit_we;
  logic        mem_llbit_val;
  logic        llbit_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_wreg    (mem_wreg),
    .mem_wd      (mem_wd),
    .mem_wdata   (mem_wdata),
    .mem_ld_type (mem_ld_type),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .wr_en       (wr_en),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .adel        (adel),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
`ifdef MEM_WB_LLBIT_EN
    ,
    .mem_llbit_we  (mem_llbit_we),
    .mem_llbit_val (mem_llbit_val),
    .llbit_o       (llbit_o)
`endif
  );

  // Reference model: contents of the WB slot plus architectural state.
  typedef struct packed {
    logic        wr_en;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
    logic        adel;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llval;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] m_hi, m_lo;
  logic        m_ll;

  // Load result from arithmetic on the raw word: shift the addressed lane
  // down, then subtract 2^n when a signed lane has its top bit set.
  task automatic ref_load(input logic [2:0] t, input logic [1:0] a,
                          input logic [31:0] rd, input logic [31:0] wd,
                          output logic [31:0] d, output logic bad);
    logic [31:0] v;
    bad = 1'b0;
    d   = wd;
    if (t == 3'd1 || t == 3'd2) begin
      v = (rd >> (8 * (3 - int'(a)))) & 32'hFF;
      d = (t == 3'd1 && v >= 32'd128) ? v - 32'd256 : v;
    end else if (t == 3'd3 || t == 3'd4) begin
      v = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
      d = (t == 3'd3 && v >= 32'd32768) ? v - 32'd65536 : v;
      bad = (a % 2) != 0;
    end else if (t == 3'd5) begin
      d   = rd;
      bad = a != 2'd0;
    end
  endtask

  task automatic model_update();
    logic [31:0] d;
    logic        bad;
    if (rst) begin
      m_slot = '0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      m_ll = 1'b0;
      return;
    end
    if (flush) m_ll = 1'b0;
    else if (m_slot.llwe) m_ll = m_slot.llval;
    if (!flush && m_slot.whilo) begin
      m_hi = m_slot.hi;
      m_lo = m_slot.lo;
    end
    if (flush || (stall[3] && !stall[4])) begin
      m_slot = '0;
    end else if (!stall[3]) begin
      ref_load(mem_ld_type, mem_addr[1:0], mem_rdata, mem_wdata, d, bad);
      m_slot.wr_en  = mem_wreg && !bad;
      m_slot.wraddr = mem_wd;
      m_slot.wrdata = d;
      m_slot.adel   = bad;
      m_slot.whilo  = mem_whilo;
      m_slot.hi     = mem_hi;
      m_slot.lo     = mem_lo;
`ifdef MEM_WB_LLBIT_EN
      m_slot.llwe   = mem_llbit_we;
      m_slot.llval  = mem_llbit_val;
`else
      m_slot.llwe   = 1'b0;
      m_slot.llval  = 1'b0;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_wr_en", {31'b0, wr_en}, {31'b0, m_slot.wr_en});
    chk("m_wraddr", {27'b0, wraddr}, {27'b0, m_slot.wraddr});
    if (!m_slot.adel) chk("m_wrdata", wrdata, m_slot.wrdata);
    chk("m_adel", {31'b0, adel}, {31'b0, m_slot.adel});
    chk("m_hi_o", hi_o, m_slot.whilo ? m_slot.hi : m_hi);
    chk("m_lo_o", lo_o, m_slot.whilo ? m_slot.lo : m_lo);
`ifdef MEM_WB_LLBIT_EN
    chk("m_llbit", {31'b0, llbit_o}, {31'b0, m_slot.llwe ? m_slot.llval : m_ll});
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic set_mem(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic [2:0] ld, input logic [31:0] addr, input logic [31:0] rdata);
    mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata;
    mem_ld_type = ld; mem_addr = addr; mem_rdata = rdata;
  endtask

  task automatic set_hilo(input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    stall = (r < 6) ? 6'b000000 : (r < 7) ? 6'b001000 : (r < 8) ? 6'b011000 : 6'($urandom);
    flush = ($urandom_range(0, 19) == 0);
    rst   = ($urandom_range(0, 63) == 0);
    set_mem(1'($urandom), 5'($urandom), $urandom, 3'($urandom), $urandom, $urandom);
    set_hilo(1'($urandom), $urandom, $urandom);
`ifdef MEM_WB_LLBIT_EN
    mem_llbit_we  = 1'($urandom);
    mem_llbit_val = 1'($urandom);
`endif
  endtask

  initial begin
    m_slot = '0; m_hi = '0; m_lo = '0; m_ll = 1'b0;
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    set_mem(1'b0, 5'd0, 32'h0, LD_NONE, 32'h0, 32'h0);
    set_hilo(1'b0, 32'h0, 32'h0);
`ifdef MEM_WB_LLBIT_EN
    mem_llbit_we = 1'b0; mem_llbit_val = 1'b0;
`endif
    #2;
    cycle();
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_hi_o", hi_o, 32'd0);
    rst = 1'b0;

    set_mem(1'b1, 5'd5, 32'h0, LD_LB, 32'h0000_1001, 32'h12F4_5678);
    cycle();
    chk("lb_wr_en", {31'b0, wr_en}, 32'd1);
    chk("lb_wraddr", {27'b0, wraddr}, 32'd5);
    chk("lb_wrdata", wrdata, 32'hFFFF_FFF4);

    mem_ld_type = LD_LBU;
    cycle();
    chk("lbu_wrdata", wrdata, 32'h0000_00F4);

    set_mem(1'b1, 5'd6, 32'h0, LD_LH, 32'h0000_2002, 32'h1234_8001);
    cycle();
    chk("lh_wrdata", wrdata, 32'hFFFF_8001);

    mem_addr = 32'h0000_2001;
    cycle();
    chk("lh_mis_wr_en", {31'b0, wr_en}, 32'd0);
    chk("lh_mis_adel", {31'b0, adel}, 32'd1);
    set_mem(1'b0, 5'd0, 32'h0, LD_NONE, 32'h0, 32'h0);
    cycle();
    chk("adel_clear", {31'b0, adel}, 32'd0);

    set_mem(1'b1, 5'd7, 32'hDEAD_BEEF, LD_NONE, 32'h0, 32'h0);
    cycle();
    chk("alu_wrdata", wrdata, 32'hDEAD_BEEF);
    stall = 6'b011000;
    set_mem(1'b1, 5'd3, 32'h1111_1111, LD_NONE, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_wrdata", wrdata, 32'hDEAD_BEEF);
      chk("hold_wraddr", {27'b0, wraddr}, 32'd7);
    end
    stall = 6'b001000;
    cycle();
    chk("mem_stall_bubble", {31'b0, wr_en}, 32'd0);
    stall = 6'b000000;

    set_mem(1'b0, 5'd0, 32'h0, LD_NONE, 32'h0, 32'h0);
    set_hilo(1'b1, 32'hA, 32'hB);
    cycle();
    chk("hilo_byp_hi", hi_o, 32'hA);
    chk("hilo_byp_lo", lo_o, 32'hB);
    set_hilo(1'b0, 32'h55, 32'h66);
    cycle();
    cycle();
    chk("hilo_arch_hi", hi_o, 32'hA);
    chk("hilo_arch_lo", lo_o, 32'hB);
    set_hilo(1'b1, 32'hC, 32'hD);
    cycle();
    chk("hilo_byp2_hi", hi_o, 32'hC);
    set_hilo(1'b0, 32'h0, 32'h0);
    cycle();
    chk("hilo_arch2_hi", hi_o, 32'hC);

    set_mem(1'b1, 5'd9, 32'h0000_1234, LD_NONE, 32'h0, 32'h0);
    set_hilo(1'b1, 32'h77, 32'h88);
    cycle();
    chk("pre_flush_wr_en", {31'b0, wr_en}, 32'd1);
    chk("pre_flush_hi", hi_o, 32'h77);
    flush = 1'b1;
    cycle();
    chk("flush_wr_en", {31'b0, wr_en}, 32'd0);
    chk("flush_hi", hi_o, 32'hC);
    chk("flush_lo", lo_o, 32'hD);
    flush = 1'b0;
    set_hilo(1'b0, 32'h0, 32'h0);
    cycle();
    chk("post_flush_hi", hi_o, 32'hC);

    set_mem(1'b1, 5'd12, 32'h0000_4321, LD_NONE, 32'h0, 32'h0);
    set_hilo(1'b1, 32'h99, 32'h98);
    cycle();
    stall = 6'b011000;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_stall_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_stall_wraddr", {27'b0, wraddr}, 32'd0);
    chk("rst_stall_wrdata", wrdata, 32'd0);
    chk("rst_stall_hi", hi_o, 32'd0);
    chk("rst_stall_lo", lo_o, 32'd0);
    rst = 1'b0;
    stall = 6'b000000;
    set_mem(1'b0, 5'd0, 32'h0, LD_NONE, 32'h0, 32'h0);
    set_hilo(1'b0, 32'h0, 32'h0);

`ifdef MEM_WB_LLBIT_EN
    mem_llbit_we = 1'b1; mem_llbit_val = 1'b1;
    cycle();
    chk("ll_bypass", {31'b0, llbit_o}, 32'd1);
    mem_llbit_we = 1'b0; mem_llbit_val = 1'b0;
    flush = 1'b1;
    cycle();
    chk("ll_flush", {31'b0, llbit_o}, 32'd0);
    flush = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
